// File: rtl/snake_game_sequencer.sv
// Snake game-state sequencer: key edge detect, game FSM,
// step pacing and a small direction request queue.
module snake_game_sequencer #(
  parameter int STEP_DIV = 1,
  parameter int QDEPTH   = 2
) (
  input  logic       CLK40HZ,
  input  logic       RESET_N,
  input  logic       ESC,
  input  logic       S,
  input  logic       P,
  input  logic       R,
  input  logic       UP,
  input  logic       DOWN,
  input  logic       LEFT,
  input  logic       RIGHT,
  input  logic       HIT,
  output logic       MOVE_EN,
  output logic       START_LOAD,
  output logic [1:0] DIR,
  output logic [2:0] STATE,
  output logic [2:0] GAME_DONEX,
  output logic [1:0] QCOUNT
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_PAUSE = 3'd2;
  localparam logic [2:0] ST_HIT   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DW-1:0] DIV_TC = DW'(STEP_DIV - 1);
  localparam logic [1:0] QMAX = 2'(QDEPTH);

  logic [7:0] key_now;
  logic [7:0] key_q;
  logic [7:0] ev;
  logic       esc_ev;
  logic       s_ev;
  logic       p_ev;
  logic       r_ev;
  logic       up_ev;
  logic       dn_ev;
  logic       lf_ev;
  logic       rt_ev;

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       run_stay;

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;
  logic          move_en_q;
  logic          move_en_d;
  logic          start_load_q;
  logic          start_load_d;
  logic [1:0]    dir_q;
  logic [1:0]    dir_d;
  logic [1:0]    cnt_q;
  logic [1:0]    cnt_d;
  logic [1:0]    q_q [4];
  logic [1:0]    q_d [4];

  logic       tc;
  logic       has_req;
  logic [1:0] req;
  logic [1:0] ref_dir;
  logic       full;
  logic       pop;
  logic       push;

  assign key_now = {ESC, S, P, R, UP, DOWN, LEFT, RIGHT};
  assign ev      = key_now & ~key_q;
  assign esc_ev  = ev[7];
  assign s_ev    = ev[6];
  assign p_ev    = ev[5];
  assign r_ev    = ev[4];
  assign up_ev   = ev[3];
  assign dn_ev   = ev[2];
  assign lf_ev   = ev[1];
  assign rt_ev   = ev[0];

  // Key history; preset high so keys held through reset stay silent
  always_ff @(posedge CLK40HZ or negedge RESET_N) begin
    if (!RESET_N) key_q <= '1;
    else          key_q <= key_now;
  end

  // Game state register
  always_ff @(posedge CLK40HZ or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state: ESC > S > HIT > P > R
  always_comb begin
    state_d = state_q;
    if (esc_ev) begin
      state_d = ST_DONE;
    end else if (s_ev) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (HIT)       state_d = ST_HIT;
          else if (p_ev) state_d = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (r_ev) state_d = ST_RUN;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Run continues this cycle with no restart or exit
  assign run_stay = (state_q == ST_RUN) && (state_d == ST_RUN) && !s_ev;

  assign tc   = (div_q == DIV_TC);
  assign full = (cnt_q == QMAX);
  assign pop  = run_stay && tc && (cnt_q != 2'd0);

  assign has_req = run_stay && (up_ev || dn_ev || lf_ev || rt_ev);
  assign req     = up_ev ? 2'b11 :
                   dn_ev ? 2'b01 :
                   lf_ev ? 2'b10 : 2'b00;
  assign ref_dir = (cnt_q != 2'd0) ? q_q[cnt_q - 2'd1] : dir_q;

  assign push = has_req
             && (req != ref_dir)
             && (req != (ref_dir ^ 2'b10))
             && (!full || pop);

  // Output/datapath next values: pacing, restart, queue
  always_comb begin
    div_d        = div_q;
    move_en_d    = 1'b0;
    start_load_d = 1'b0;
    dir_d        = dir_q;
    cnt_d        = cnt_q;
    for (int i = 0; i < 4; i++) q_d[i] = q_q[i];
    if (s_ev && !esc_ev) begin
      start_load_d = 1'b1;
      dir_d        = 2'b00;
      cnt_d        = 2'd0;
      div_d        = '0;
    end else if (state_d == ST_HIT || state_d == ST_DONE) begin
      cnt_d = 2'd0;
    end else if (run_stay) begin
      div_d     = tc ? '0 : div_q + 1'b1;
      move_en_d = tc;
      if (pop) begin
        dir_d = q_q[0];
        for (int i = 0; i < 3; i++) q_d[i] = q_q[i+1];
        q_d[3] = 2'b00;
      end
      if (push) begin
        q_d[pop ? cnt_q - 2'd1 : cnt_q] = req;
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Registered outputs, divider and queue storage
  always_ff @(posedge CLK40HZ or negedge RESET_N) begin
    if (!RESET_N) begin
      div_q        <= '0;
      move_en_q    <= 1'b0;
      start_load_q <= 1'b0;
      dir_q        <= 2'b00;
      cnt_q        <= 2'd0;
      for (int i = 0; i < 4; i++) q_q[i] <= 2'b00;
    end else begin
      div_q        <= div_d;
      move_en_q    <= move_en_d;
      start_load_q <= start_load_d;
      dir_q        <= dir_d;
      cnt_q        <= cnt_d;
      for (int i = 0; i < 4; i++) q_q[i] <= q_d[i];
    end
  end

  assign MOVE_EN    = move_en_q;
  assign START_LOAD = start_load_q;
  assign DIR        = dir_q;
  assign STATE      = state_q;
  assign QCOUNT     = cnt_q;
  assign GAME_DONEX = {state_q == ST_PAUSE,
                       state_q == ST_DONE,
                       state_q == ST_HIT};

endmodule

// File: tb/tb_snake_game_sequencer.sv
// Directed bench for snake_game_sequencer with an
// expected-output scoreboard, STEP_DIV=4, QDEPTH=2.
module tb_snake_game_sequencer;

  localparam logic [7:0] K0   = 8'h00;
  localparam logic [7:0] KESC = 8'h80;
  localparam logic [7:0] KS   = 8'h40;
  localparam logic [7:0] KP   = 8'h20;
  localparam logic [7:0] KR   = 8'h10;
  localparam logic [7:0] KU   = 8'h08;
  localparam logic [7:0] KD   = 8'h04;
  localparam logic [7:0] KL   = 8'h02;
  localparam logic [7:0] KRT  = 8'h01;

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] dir;
    logic       mv;
    logic       sl;
    logic [1:0] qc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] keys;
  logic       hit;
  logic       move_en;
  logic       start_load;
  logic [1:0] dir;
  logic [2:0] state;
  logic [2:0] gdx;
  logic [1:0] qcount;

  int   checks;
  int   failures;
  int   cyc_n;
  exp_t sb[$];

  snake_game_sequencer #(.STEP_DIV(4), .QDEPTH(2)) dut (
    .CLK40HZ    (clk),
    .RESET_N    (rst_n),
    .ESC        (keys[7]),
    .S          (keys[6]),
    .P          (keys[5]),
    .R          (keys[4]),
    .UP         (keys[3]),
    .DOWN       (keys[2]),
    .LEFT       (keys[1]),
    .RIGHT      (keys[0]),
    .HIT        (hit),
    .MOVE_EN    (move_en),
    .START_LOAD (start_load),
    .DIR        (dir),
    .STATE      (state),
    .GAME_DONEX (gdx),
    .QCOUNT     (qcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] gdx_of(input logic [2:0] s);
    case (s)
      3'd2:    return 3'b100;
      3'd3:    return 3'b001;
      3'd4:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
             tag, cyc_n, obs, exp);
    end
  endtask

  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL sb_empty cyc=%0d observed=0 expected=1", cyc_n);
    end else begin
      e = sb.pop_front();
      chk("state",  8'(state),      8'(e.st));
      chk("gdx",    8'(gdx),        8'(gdx_of(e.st)));
      chk("dir",    8'(dir),        8'(e.dir));
      chk("move",   8'(move_en),    8'(e.mv));
      chk("sload",  8'(start_load), 8'(e.sl));
      chk("qcount", 8'(qcount),     8'(e.qc));
    end
  endtask

  task automatic rst_check();
    exp_t e;
    e = '0;
    sb.push_back(e);
    compare();
  endtask

  task automatic step(input logic [7:0] k, input logic h,
                      input logic [2:0] st, input logic [1:0] d,
                      input logic mv, input logic sl,
                      input logic [1:0] qc);
    exp_t e;
    @(negedge clk);
    keys = k;
    hit  = h;
    e.st  = st;
    e.dir = d;
    e.mv  = mv;
    e.sl  = sl;
    e.qc  = qc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc_n++;
    compare();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d observed=timeout expected=finish",
             cyc_n);
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    cyc_n    = 0;
    rst_n    = 1'b0;
    keys     = K0;
    hit      = 1'b0;
    #2;
    rst_check();
    @(negedge clk);
    rst_n = 1'b1;
    step(K0, 0, 0, 0, 0, 0, 0);
    // start and pacing
    step(KS, 0, 1, 0, 0, 1, 0);
    step(K0, 0, 1, 0, 0, 0, 0);
    step(K0, 0, 1, 0, 0, 0, 0);
    step(K0, 0, 1, 0, 0, 0, 0);
    step(K0, 0, 1, 0, 1, 0, 0);
    step(K0, 0, 1, 0, 0, 0, 0);
    step(K0, 0, 1, 0, 0, 0, 0);
    step(K0, 0, 1, 0, 0, 0, 0);
    step(K0, 0, 1, 0, 1, 0, 0);
    // UP then LEFT queued, applied on strobes
    step(KU, 0, 1, 0, 0, 0, 1);
    step(KL, 0, 1, 0, 0, 0, 2);
    step(K0, 0, 1, 0, 0, 0, 2);
    step(K0, 0, 1, 3, 1, 0, 1);
    step(K0, 0, 1, 3, 0, 0, 1);
    step(K0, 0, 1, 3, 0, 0, 1);
    step(K0, 0, 1, 3, 0, 0, 1);
    step(K0, 0, 1, 2, 1, 0, 0);
    // restart, reverse drop, full drop, push+pop when full
    step(KS,  0, 1, 0, 0, 1, 0);
    step(KL,  0, 1, 0, 0, 0, 0);
    step(KU,  0, 1, 0, 0, 0, 1);
    step(KRT, 0, 1, 0, 0, 0, 2);
    step(K0,  0, 1, 3, 1, 0, 1);
    step(KD,  0, 1, 3, 0, 0, 2);
    step(KL,  0, 1, 3, 0, 0, 2);
    step(K0,  0, 1, 3, 0, 0, 2);
    step(KL,  0, 1, 0, 1, 0, 2);
    // pause holds divider and queue
    step(KP, 0, 2, 0, 0, 0, 2);
    step(K0, 1, 2, 0, 0, 0, 2);
    step(KP, 0, 2, 0, 0, 0, 2);
    step(KR, 0, 1, 0, 0, 0, 2);
    step(K0, 0, 1, 0, 0, 0, 2);
    step(KR, 0, 1, 0, 0, 0, 2);
    step(K0, 0, 1, 0, 0, 0, 2);
    step(K0, 0, 1, 1, 1, 0, 1);
    // HIT beats P, ESC beats S
    step(KP,      1, 3, 1, 0, 0, 0);
    step(K0,      1, 3, 1, 0, 0, 0);
    step(KESC|KS, 0, 4, 1, 0, 0, 0);
    step(K0,      0, 4, 1, 0, 0, 0);
    step(KS,      0, 1, 0, 0, 1, 0);
    step(KU,      0, 1, 0, 0, 0, 1);
    step(KL,      0, 1, 0, 0, 0, 2);
    // async reset mid-run with keys held
    @(negedge clk);
    keys  = KU | KS;
    rst_n = 1'b0;
    #1;
    rst_check();
    @(negedge clk);
    rst_n = 1'b1;
    step(KU|KS, 0, 0, 0, 0, 0, 0);
    step(KU,    0, 0, 0, 0, 0, 0);
    step(KU|KS, 0, 1, 0, 0, 1, 0);
    step(KU,    0, 1, 0, 0, 0, 0);
    step(K0,    0, 1, 0, 0, 0, 0);
    step(KU,    0, 1, 0, 0, 0, 1);
    step(KESC,  0, 4, 0, 0, 0, 0);
    step(K0,    0, 4, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
